fetch_stage: RTL and testbench

- Instruction fetch stage of the tinyRISC pipeline: owns the PC, issues word reads to instruction memory over a req/gnt/rvalid handshake, and presents the fetched instruction plus its PC to decode.
- Sits directly upstream of decode and immediate generation, which take if_instr.
- Handles decode back-pressure through a one-entry skid buffer.
- Accepts redirects (branch/jump targets) from execute, squashing in-flight and buffered instructions.

---
 rtl/tinyrisc_pkg.sv | 29 ++
 rtl/fetch_skid_buf.sv | 46 ++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyrisc_pkg.sv
// tinyRISC shared definitions: opcodes, nop encoding, PC width,
// fetch FSM states and the fetch->decode bundle.
package tinyrisc_pkg;

    localparam int unsigned PC_W = 16;

    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_ST  = 5'b00001;
    localparam logic [4:0] OP_JMP = 5'b01000;
    localparam logic [4:0] OP_BEQ = 5'b01001;
    localparam logic [4:0] OP_BNE = 5'b01010;
    localparam logic [4:0] OP_BLT = 5'b01011;
    localparam logic [4:0] OP_NOP = 5'b01101;

    localparam logic [31:0] NOP_INSTR = {OP_NOP, 27'd0};

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+pc holding register for decode back-pressure.
// Ports: load/unload/flush controls, d in, valid/q out.
module fetch_skid_buf
    import tinyrisc_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   unload,
    input  logic   flush,
    input  if_id_t d,
    output logic   valid,
    output if_id_t q
);

    logic   valid_q, valid_d;
    if_id_t data_q, data_d;

    // Load wins over unload so a same-cycle refill keeps the entry live.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule

// File: rtl/fetch_stage.sv
// tinyRISC instruction fetch: owns the PC, reads imem over req/gnt/rvalid,
// feeds decode via if_* with a one-entry skid; redirects squash everything.
module fetch_stage
    import tinyrisc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            id_stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] gpc_q, gpc_d;
    logic            out_valid_q, out_valid_d;
    if_id_t          out_q, out_d;

    logic   skid_valid, skid_load, skid_unload;
    if_id_t skid_q, resp_word;
    logic   grant, consume, resp;

    assign imem_req  = (state_q == S_ISSUE) & ~skid_valid;
    assign imem_addr = pc_q;
    assign grant     = imem_req & imem_gnt;
    assign consume   = out_valid_q & ~id_stall;
    // A response only counts when it answers a live (not squashed) request.
    assign resp      = imem_rvalid & (state_q == S_WAIT) & ~redirect_valid;
    assign resp_word = '{instr: imem_rdata, pc: gpc_q};
    assign gpc_d     = grant ? pc_q : gpc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_START: state_d = S_ISSUE;
            S_ISSUE: begin
                if (grant) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid)         state_d = S_ISSUE;
                else if (redirect_valid) state_d = S_DROP;
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_ISSUE;
            end
            default: state_d = S_START;
        endcase
        if (redirect_valid) pc_d = redirect_pc;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        if (redirect_valid) begin
            out_valid_d = 1'b0;
            out_d.instr = NOP_INSTR;
        end else if (consume && skid_valid) begin
            out_valid_d = 1'b1;
            out_d       = skid_q;
            skid_unload = 1'b1;
            skid_load   = resp;
        end else if (!out_valid_q || consume) begin
            if (resp) begin
                out_valid_d = 1'b1;
                out_d       = resp_word;
            end else if (consume) begin
                out_valid_d = 1'b0;
                out_d.instr = NOP_INSTR;
            end
        end else if (resp) begin
            skid_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_START;
            pc_q        <= RESET_PC;
            gpc_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '{instr: NOP_INSTR, pc: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            gpc_q       <= gpc_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .unload (skid_unload),
        .flush  (redirect_valid),
        .d      (resp_word),
        .valid  (skid_valid),
        .q      (skid_q)
    );

    assign if_valid = out_valid_q;
    assign if_instr = out_q.instr;
    assign if_pc    = out_q.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural instruction memory
// plus directed and randomized scenarios checked against fetch order rules.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h6800_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned proto_err = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] seed = 32'h1357_9bdf;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hC0DE, ~a} ^ seed;
    endfunction

    // Instruction memory: one response per grant, latency lat_min..lat_max.
    initial begin : mem_model
        bit          pend;
        int          pcnt;
        logic [15:0] paddr;
        bit          prev_hold;
        logic [15:0] prev_addr;
        pend = 0; pcnt = 0; paddr = '0; prev_hold = 0; prev_addr = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                pend = 0; imem_rvalid = 0; imem_gnt = 0; prev_hold = 0;
            end else begin
                if (prev_hold && !redirect_valid &&
                    (imem_req !== 1'b1 || imem_addr !== prev_addr))
                    proto_err++;
                imem_rvalid = 0;
                imem_rdata  = $urandom;
                if (pend) begin
                    if (pcnt <= 1) begin
                        imem_rvalid = 1;
                        imem_rdata  = mem_word(paddr);
                        pend = 0;
                    end else pcnt--;
                end
                if (imem_req && (pend || imem_rvalid)) proto_err++;
                imem_gnt = ($urandom_range(99) < gnt_pct);
                if (imem_req && imem_gnt) begin
                    pend  = 1;
                    paddr = imem_addr;
                    pcnt  = $urandom_range(lat_max, lat_min);
                end
                prev_hold = imem_req && !imem_gnt;
                prev_addr = imem_addr;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic apply_reset();
        rst_n = 0; id_stall = 0; redirect_valid = 0; redirect_pc = '0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 1; id_stall = 0; redirect_valid = 0; redirect_pc = '0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        #1 rst_n = 0;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_valid); else n_pass++;
        n_total++; if (if_instr !== NOP) $display("FAIL reset_instr got %h want %h", if_instr, NOP); else n_pass++;
        n_total++; if (if_pc !== 16'h0) $display("FAIL reset_pc got %h want 0000", if_pc); else n_pass++;
        tick(); tick();
        rst_n = 1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL start_idle got %b want 0", imem_req); else n_pass++;
        tick();
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0)
            $display("FAIL first_req got %b/%h want 1/0000", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [15:0] ea, ep;
        bit seen, prv;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();
        ea = 0; ep = 0; seen = 0; prv = 0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_gnt) begin
                n_total++;
                if (imem_addr !== ea) $display("FAIL stream_addr got %h want %h", imem_addr, ea);
                else n_pass++;
                ea++;
            end
            if (if_valid) begin
                if (!seen) begin
                    n_total++;
                    if (prv !== 1'b1) $display("FAIL stream_latency got prev_rvalid=%b want 1", prv);
                    else n_pass++;
                    seen = 1;
                end
                n_total++;
                if (if_pc !== ep || if_instr !== mem_word(ep))
                    $display("FAIL stream_data got %h/%h want %h/%h", if_pc, if_instr, ep, mem_word(ep));
                else n_pass++;
                ep++;
            end
            prv = imem_rvalid;
            tick();
        end
        n_total++; if (ep < 16'd15) $display("FAIL stream_count got %0d want >=15", ep); else n_pass++;
    endtask

    task automatic test_stall();
        logic [15:0] ep, hpc;
        logic [31:0] hin;
        bit ok;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (if_valid) ok = 1; else tick();
        end
        n_total++; if (!ok) $display("FAIL stall_setup got timeout want if_valid"); else n_pass++;
        id_stall = 1;
        hpc = if_pc; hin = if_instr;
        n_total++; if (hpc !== 16'h0) $display("FAIL stall_first_pc got %h want 0000", hpc); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (if_valid !== 1'b1 || if_pc !== hpc || if_instr !== hin)
                $display("FAIL stall_hold got %b/%h/%h want 1/%h/%h", if_valid, if_pc, if_instr, hpc, hin);
            else n_pass++;
            if (k == 2) begin
                n_total++;
                if (imem_req !== 1'b0) $display("FAIL stall_skid_req got %b want 0", imem_req);
                else n_pass++;
            end
            tick();
        end
        id_stall = 0;
        ep = 0;
        for (int i = 0; i < 30; i++) begin
            if (if_valid) begin
                n_total++;
                if (if_pc !== ep || if_instr !== mem_word(ep))
                    $display("FAIL stall_order got %h/%h want %h/%h", if_pc, if_instr, ep, mem_word(ep));
                else n_pass++;
                ep++;
            end
            tick();
        end
        n_total++; if (ep < 16'd12) $display("FAIL stall_count got %0d want >=12", ep); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        bit ok, seen;
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        apply_reset();
        tick();
        n_total++;
        if (!(imem_req && imem_gnt)) $display("FAIL rdw_setup got req=%b gnt=%b want 1/1", imem_req, imem_gnt);
        else n_pass++;
        tick();
        redirect_valid = 1; redirect_pc = 16'h0040;
        tick();
        redirect_valid = 0;
        ok = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (imem_req && imem_gnt && !ok) begin
                ok = 1;
                n_total++;
                if (imem_addr !== 16'h0040) $display("FAIL rdw_addr got %h want 0040", imem_addr);
                else n_pass++;
            end
            if (if_valid) begin
                seen = 1;
                n_total++;
                if (if_pc !== 16'h0040 || if_instr !== mem_word(16'h0040))
                    $display("FAIL rdw_first got %h/%h want 0040/%h", if_pc, if_instr, mem_word(16'h0040));
                else n_pass++;
            end else tick();
        end
        n_total++; if (!seen) $display("FAIL rdw_timeout got none want if_valid"); else n_pass++;
    endtask

    task automatic test_redirect_skid();
        logic [15:0] rp, ep, d;
        bit ok;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (if_valid) ok = 1; else tick();
        end
        id_stall = 1;
        tick(); tick();
        n_total++;
        if (!ok || imem_req !== 1'b0) $display("FAIL rds_setup got req=%b want 0 (skid full)", imem_req);
        else n_pass++;
        rp = 16'($urandom) | 16'h0100;
        redirect_valid = 1; redirect_pc = rp;
        tick();
        redirect_valid = 0;
        n_total++;
        if (if_valid !== 1'b0 || if_instr !== NOP)
            $display("FAIL rds_squash got %b/%h want 0/%h", if_valid, if_instr, NOP);
        else n_pass++;
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== rp)
            $display("FAIL rds_addr got %b/%h want 1/%h", imem_req, imem_addr, rp);
        else n_pass++;
        id_stall = 0;
        ep = rp;
        for (int i = 0; i < 20; i++) begin
            if (if_valid) begin
                n_total++;
                if (if_pc !== ep || if_instr !== mem_word(ep))
                    $display("FAIL rds_order got %h/%h want %h/%h", if_pc, if_instr, ep, mem_word(ep));
                else n_pass++;
                ep++;
            end
            tick();
        end
        d = ep - rp;
        n_total++; if (d < 16'd3) $display("FAIL rds_count got %0d want >=3", d); else n_pass++;
    endtask

    task automatic test_gnt_low();
        bit ok;
        gnt_pct = 0; lat_min = 1; lat_max = 1;
        apply_reset();
        tick();
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0 || imem_gnt !== 1'b0)
                $display("FAIL gnt_low_hold got %b/%h/%b want 1/0000/0", imem_req, imem_addr, imem_gnt);
            else n_pass++;
            if (k == 3) gnt_pct = 100;
            tick();
        end
        n_total++;
        if (!(imem_req && imem_gnt) || imem_addr !== 16'h0)
            $display("FAIL gnt_low_grant got %b%b/%h want 11/0000", imem_req, imem_gnt, imem_addr);
        else n_pass++;
        tick();
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (imem_req && imem_gnt) begin
                ok = 1;
                n_total++;
                if (imem_addr !== 16'h0001) $display("FAIL gnt_low_next got %h want 0001", imem_addr);
                else n_pass++;
            end else tick();
        end
        n_total++; if (!ok) $display("FAIL gnt_low_timeout got none want grant"); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [15:0] ea, ep, d;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();
        tick();
        n_total++;
        if (!(imem_req && imem_gnt)) $display("FAIL wrap_setup got req=%b gnt=%b want 1/1", imem_req, imem_gnt);
        else n_pass++;
        redirect_valid = 1; redirect_pc = 16'hFFFF;
        tick();
        redirect_valid = 0;
        ea = 16'hFFFF; ep = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            if (imem_req && imem_gnt) begin
                n_total++;
                if (imem_addr !== ea) $display("FAIL wrap_addr got %h want %h", imem_addr, ea);
                else n_pass++;
                ea++;
            end
            if (if_valid) begin
                n_total++;
                if (if_pc !== ep || if_instr !== mem_word(ep))
                    $display("FAIL wrap_data got %h/%h want %h/%h", if_pc, if_instr, ep, mem_word(ep));
                else n_pass++;
                ep++;
            end
            tick();
        end
        d = ep - 16'hFFFF;
        n_total++; if (d < 16'd3) $display("FAIL wrap_count got %0d want >=3", d); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        apply_reset();
        id_stall = 1;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (if_valid) ok = 1; else tick();
        end
        for (int i = 0; i < 10 && ok; i++) begin
            if (imem_req && imem_gnt) ok = 0; else tick();
        end
        n_total++; if (ok) $display("FAIL async_setup got timeout want grant"); else n_pass++;
        tick();
        n_total++; if (if_valid !== 1'b1) $display("FAIL async_pre got %b want 1", if_valid); else n_pass++;
        rst_n = 0;
        #1;
        n_total++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 16'h0)
            $display("FAIL async_reset got %b/%b/%h/%h want 0/0/%h/0000", imem_req, if_valid, if_instr, if_pc, NOP);
        else n_pass++;
        id_stall = 0;
    endtask

    task automatic test_random();
        logic [15:0] ep, hpc, rp;
        logic [31:0] hin;
        bit held, pred, st, rd;
        int ndel;
        for (int it = 0; it < 4; it++) begin
            gnt_pct = $urandom_range(100, 30);
            lat_min = 1; lat_max = $urandom_range(4, 1);
            apply_reset();
            ep = 16'h0; held = 0; pred = 0; ndel = 0; hpc = '0; hin = '0;
            for (int c = 0; c < 300; c++) begin
                if (held) begin
                    n_total++;
                    if (if_valid !== 1'b1 || if_pc !== hpc || if_instr !== hin)
                        $display("FAIL rnd_hold got %b/%h/%h want 1/%h/%h", if_valid, if_pc, if_instr, hpc, hin);
                    else n_pass++;
                end
                if (pred) begin
                    n_total++;
                    if (if_valid !== 1'b0) $display("FAIL rnd_squash got %b want 0", if_valid);
                    else n_pass++;
                end
                if (!if_valid) begin
                    n_total++;
                    if (if_instr !== NOP) $display("FAIL rnd_nop got %h want %h", if_instr, NOP);
                    else n_pass++;
                end
                st = ($urandom_range(99) < 30);
                rd = ($urandom_range(99) < 4);
                rp = 16'($urandom);
                id_stall = st; redirect_valid = rd; redirect_pc = rp;
                if (if_valid && !st && !rd) begin
                    n_total++;
                    if (if_pc !== ep || if_instr !== mem_word(ep))
                        $display("FAIL rnd_order got %h/%h want %h/%h", if_pc, if_instr, ep, mem_word(ep));
                    else n_pass++;
                    ep++;
                    ndel++;
                end
                held = if_valid && st && !rd;
                hpc = if_pc; hin = if_instr;
                pred = rd;
                if (rd) ep = rp;
                tick();
            end
            id_stall = 0; redirect_valid = 0;
            n_total++; if (ndel < 10) $display("FAIL rnd_progress got %0d want >=10", ndel); else n_pass++;
        end
    endtask

    task automatic test_protocol();
        n_total++;
        if (proto_err != 0) $display("FAIL imem_protocol got %0d errors want 0", proto_err);
        else n_pass++;
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_skid();
        test_gnt_low();
        test_wrap();
        test_async_reset();
        test_random();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
